// File: rtl/disp_scan_mux.sv
// Multiplexed seven-segment debug display: manual/auto channel select, tear-free
// shadow word, digit scan with leading-zero blanking and a channel-index decimal point.
module disp_scan_mux #(
  parameter int N_CHAN      = 4,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 131072,
  parameter int AUTO_PERIOD = 100000000,
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int SW = $clog2(SCAN_DIV),
  localparam int AW = $clog2(AUTO_PERIOD),
  localparam int WW = DIGITS * 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CHAN*DIGITS*4-1:0] chan_data,
  input  logic [CW-1:0]            sel,
  input  logic                     mode,
  input  logic                     step,
  input  logic                     blank_lz,
  input  logic                     freeze,
  output logic [DIGITS-1:0]        pos_ctrl,
  output logic [7:0]               num_ctrl,
  output logic [CW-1:0]            cur_chan
);

  logic [SW-1:0]     scan_cnt_r;
  logic [DW-1:0]     digit_r;
  logic [AW-1:0]     dwell_r;
  logic [AW-1:0]     dwell_nxt_s;
  logic [CW-1:0]     chan_r;
  logic [CW-1:0]     chan_nxt_s;
  logic [CW-1:0]     sel_clamp_s;
  logic              chan_chg_r;
  logic [WW-1:0]     shadow_r;
  logic [WW-1:0]     word_s;
  logic [DIGITS-1:0] pos_r;
  logic [DIGITS-1:0] pos_s;
  logic [7:0]        num_r;
  logic [7:0]        num_s;
  logic [3:0]        nib_s;
  logic              scan_tc_s;
  logic              digit_wrap_s;
  logic              dwell_tc_s;
  logic              nz_s;
  logic              blank_s;
  logic              dp_s;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      4'hF:    hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  endfunction

  assign scan_tc_s    = (scan_cnt_r == SW'(SCAN_DIV - 1));
  assign digit_wrap_s = scan_tc_s && (digit_r == DW'(DIGITS - 1));
  assign dwell_tc_s   = (dwell_r == AW'(AUTO_PERIOD - 1));

  // Next channel and dwell count; step and terminal count share one increment.
  always_comb begin
    sel_clamp_s = sel;
    chan_nxt_s  = chan_r;
    dwell_nxt_s = '0;
    if (int'(sel) >= N_CHAN) begin
      sel_clamp_s = CW'(N_CHAN - 1);
    end else begin
      sel_clamp_s = sel;
    end
    if (!mode) begin
      chan_nxt_s  = sel_clamp_s;
      dwell_nxt_s = '0;
    end else if (step || dwell_tc_s) begin
      chan_nxt_s  = (chan_r == CW'(N_CHAN - 1)) ? '0 : chan_r + 1'b1;
      dwell_nxt_s = '0;
    end else begin
      chan_nxt_s  = chan_r;
      dwell_nxt_s = dwell_r + 1'b1;
    end
  end

  // Channel word select, current-digit decode, blanking and decimal point.
  always_comb begin
    word_s = '0;
    nib_s  = 4'h0;
    nz_s   = 1'b0;
    pos_s  = '1;
    for (int k = 0; k < N_CHAN; k++) begin
      word_s = (chan_r == CW'(k)) ? chan_data[k*WW +: WW] : word_s;
    end
    for (int k = 0; k < DIGITS; k++) begin
      nib_s    = (digit_r == DW'(k)) ? shadow_r[k*4 +: 4] : nib_s;
      nz_s     = nz_s | ((k >= int'(digit_r)) && (shadow_r[k*4 +: 4] != 4'h0));
      pos_s[k] = (digit_r != DW'(k));
    end
    blank_s = blank_lz && (digit_r != '0) && !nz_s;
    dp_s    = (int'(chan_r) < DIGITS) && (int'(digit_r) == int'(chan_r));
    num_s   = {~dp_s, blank_s ? 7'h7F : hex_seg(nib_s)};
  end

  // Scan divider and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      digit_r    <= '0;
    end else if (scan_tc_s) begin
      scan_cnt_r <= '0;
      digit_r    <= digit_wrap_s ? '0 : digit_r + 1'b1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 1'b1;
    end
  end

  // Displayed channel, dwell counter and channel-change flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_r     <= '0;
      dwell_r    <= '0;
      chan_chg_r <= 1'b0;
    end else begin
      chan_r     <= chan_nxt_s;
      dwell_r    <= dwell_nxt_s;
      chan_chg_r <= (chan_nxt_s != chan_r);
    end
  end

  // Shadow word reloads only at frame boundaries or right after a channel change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
    end else if (!freeze && (digit_wrap_s || chan_chg_r)) begin
      shadow_r <= word_s;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Digit enable and segments update together at the end of each scan slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r <= '1;
      num_r <= 8'hFF;
    end else if (scan_tc_s) begin
      pos_r <= pos_s;
      num_r <= num_s;
    end else begin
      pos_r <= pos_r;
      num_r <= num_r;
    end
  end

  assign pos_ctrl = pos_r;
  assign num_ctrl = num_r;
  assign cur_chan = chan_r;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux: scan order, blanking, freeze, auto-rotate, clamp, reset.
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] chan_data_a;
  logic [1:0]  sel_a;
  logic        mode_a, step_a, blank_a, freeze_a;
  logic [3:0]  pos_a;
  logic [7:0]  num_a;
  logic [1:0]  cur_a;
  logic [47:0] chan_data_b;
  logic [1:0]  sel_b;
  logic [3:0]  pos_b;
  logic [7:0]  num_b;
  logic [1:0]  cur_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scan_mux #(.N_CHAN(4), .DIGITS(4), .SCAN_DIV(4), .AUTO_PERIOD(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .chan_data(chan_data_a), .sel(sel_a), .mode(mode_a),
    .step(step_a), .blank_lz(blank_a), .freeze(freeze_a),
    .pos_ctrl(pos_a), .num_ctrl(num_a), .cur_chan(cur_a));

  disp_scan_mux #(.N_CHAN(3), .DIGITS(4), .SCAN_DIV(4), .AUTO_PERIOD(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .chan_data(chan_data_b), .sel(sel_b), .mode(1'b0),
    .step(1'b0), .blank_lz(1'b0), .freeze(1'b0),
    .pos_ctrl(pos_b), .num_ctrl(num_b), .cur_chan(cur_b));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for digit d to be enabled, then check its segments.
  task automatic show_digit(input int d, input logic [7:0] exp_num, input string tag);
    logic [3:0] one;
    logic [3:0] exp_pos;
    int n;
    one = 4'b0001 << d;
    exp_pos = ~one;
    n = 0;
    while (pos_a !== exp_pos && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pos"}, 8'(pos_a), 8'(exp_pos));
    chk({tag, "_num"}, num_a, exp_num);
  endtask

  initial begin
    chan_data_a = 64'h0000_0000_0000_12AF;
    chan_data_b = 48'h0;
    sel_a = 2'd0; mode_a = 1'b0; step_a = 1'b0; blank_a = 1'b0; freeze_a = 1'b0;
    sel_b = 2'd0;
    #12;
    chk("rst_pos", 8'(pos_a), 8'h0F);
    chk("rst_num", num_a, 8'hFF);
    chk("rst_cur", 8'(cur_a), 8'h00);
    chk("rst_pos_b", 8'(pos_b), 8'h0F);
    chk("rst_num_b", num_b, 8'hFF);

    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("first_pos_early", 8'(pos_a), 8'h0F);
    @(negedge clk);
    chk("first_pos", 8'(pos_a), 8'h0E);
    chk("first_num_unloaded", num_a, 8'h40);

    // Scan, no blanking: channel 0 = 12AF, dp on digit 0
    repeat (40) @(negedge clk);
    show_digit(0, 8'h0E, "scan_d0");
    show_digit(1, 8'h88, "scan_d1");
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scan_period_pos", 8'(pos_a), 8'h0B);
    chk("scan_d2_num", num_a, 8'hA4);
    show_digit(3, 8'hF9, "scan_d3");

    // Channel clamp on the three-channel instance
    @(negedge clk) sel_b = 2'd3;
    @(negedge clk);
    chk("clamp_sel3", 8'(cur_b), 8'h02);
    sel_b = 2'd1;
    @(negedge clk);
    chk("clamp_sel1", 8'(cur_b), 8'h01);

    // Leading-zero blanking on channel 1 = 0030
    chan_data_a[31:16] = 16'h0030;
    sel_a = 2'd1; blank_a = 1'b1;
    @(negedge clk);
    chk("sel_latency", 8'(cur_a), 8'h01);
    repeat (40) @(negedge clk);
    show_digit(0, 8'hC0, "lz_d0");
    show_digit(1, 8'h30, "lz_d1");
    show_digit(2, 8'hFF, "lz_d2");
    show_digit(3, 8'hFF, "lz_d3");

    // Freeze: word held, channel and dp follow sel
    freeze_a = 1'b1;
    chan_data_a[47:32] = 16'h00B7;
    sel_a = 2'd2;
    @(negedge clk);
    chk("frz_cur", 8'(cur_a), 8'h02);
    repeat (40) @(negedge clk);
    show_digit(1, 8'hB0, "frz_d1");
    show_digit(2, 8'h7F, "frz_d2_dp_blank");
    freeze_a = 1'b0;
    repeat (40) @(negedge clk);
    show_digit(0, 8'hF8, "unfrz_d0");
    show_digit(1, 8'h83, "unfrz_d1");

    // Auto-rotate from channel 2
    mode_a = 1'b1;
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("auto_hold2", 8'(cur_a), 8'h02);
    @(negedge clk);
    chk("auto_adv3", 8'(cur_a), 8'h03);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("auto_hold3", 8'(cur_a), 8'h03);
    @(negedge clk);
    chk("auto_wrap0", 8'(cur_a), 8'h00);

    // Step at dwell 10
    repeat (10) @(posedge clk);
    @(negedge clk) step_a = 1'b1;
    @(negedge clk) step_a = 1'b0;
    chk("step_adv", 8'(cur_a), 8'h01);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("step_dwell_hold", 8'(cur_a), 8'h01);
    @(negedge clk);
    chk("step_dwell_adv", 8'(cur_a), 8'h02);

    // Step coincident with terminal count
    repeat (63) @(posedge clk);
    @(negedge clk) step_a = 1'b1;
    chk("coinc_before", 8'(cur_a), 8'h02);
    @(negedge clk) step_a = 1'b0;
    chk("coinc_single", 8'(cur_a), 8'h03);

    // Back to manual, step ignored
    mode_a = 1'b0; sel_a = 2'd0; step_a = 1'b1;
    @(negedge clk);
    chk("manual_return", 8'(cur_a), 8'h00);
    @(negedge clk);
    chk("manual_step_ign", 8'(cur_a), 8'h00);
    step_a = 1'b0;
    sel_a = 2'd3;
    repeat (30) @(negedge clk);

    // Asynchronous reset mid-slot
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos", 8'(pos_a), 8'h0F);
    chk("arst_num", num_a, 8'hFF);
    chk("arst_cur", 8'(cur_a), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
